// File: rtl/cpu6_hazard_ctrl_pkg.sv
// Shared state encodings, control-bundle type and load-use compare for the
// cpu6 hazard sequencer.
package cpu6_hazard_ctrl_pkg;

  localparam int CPU6_HAZ_STATE_SIZE = 2;

  localparam logic [CPU6_HAZ_STATE_SIZE-1:0] CPU6_HAZ_IDLE    = 2'd0;
  localparam logic [CPU6_HAZ_STATE_SIZE-1:0] CPU6_HAZ_DRAIN   = 2'd1;
  localparam logic [CPU6_HAZ_STATE_SIZE-1:0] CPU6_HAZ_RELEASE = 2'd2;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic flash_d;
    logic flash_e;
  } haz_ctrl_t;

  localparam haz_ctrl_t HAZ_NONE     = '{stall_f: 1'b0, stall_d: 1'b0, flash_d: 1'b0, flash_e: 1'b0};
  localparam haz_ctrl_t HAZ_REDIRECT = '{stall_f: 1'b0, stall_d: 1'b0, flash_d: 1'b1, flash_e: 1'b1};
  localparam haz_ctrl_t HAZ_STALL    = '{stall_f: 1'b1, stall_d: 1'b1, flash_d: 1'b0, flash_e: 1'b1};

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  function automatic logic load_use(input logic       memtoreg,
                                    input logic [4:0] rd,
                                    input logic [4:0] rs1,
                                    input logic [4:0] rs2,
                                    input logic       use1,
                                    input logic       use2);
    return memtoreg && (rd != 5'd0) &&
           ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/cpu6_hazard_ctrl_if.sv
// Decoder-side bundle of the hazard sequencer: hazard inputs from D/E and the
// pipeline-register controls back.
interface cpu6_hazard_ctrl_if #(parameter int PERF_W = 16);

  logic              memtoregE;
  logic [4:0]        rdE;
  logic [4:0]        rs1D;
  logic [4:0]        rs2D;
  logic              use_rs1D;
  logic              use_rs2D;
  logic              redirectE;
  logic              empty_pipeline_reqE;
  logic              stallF;
  logic              stallD;
  logic              flashD;
  logic              flashE;
  logic              drain_busy;
  logic              drain_done;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output memtoregE, rdE, rs1D, rs2D, use_rs1D, use_rs2D, redirectE, empty_pipeline_reqE,
    input  stallF, stallD, flashD, flashE, drain_busy, drain_done, stall_cnt
  );

  modport slave (
    input  memtoregE, rdE, rs1D, rs2D, use_rs1D, use_rs2D, redirectE, empty_pipeline_reqE,
    output stallF, stallD, flashD, flashE, drain_busy, drain_done, stall_cnt
  );

endinterface

// File: rtl/cpu6_dffr.sv
// Resettable D flip-flop bank; next-state muxing is done by the caller.
module cpu6_dffr #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) o_q <= RST_VAL;
    else       o_q <= i_d;
  end

endmodule

// File: rtl/cpu6_hazard_drain_fsm.sv
// Drain sequencer: IDLE -> DRAIN (DRAIN_CYCLES cycles) -> RELEASE -> IDLE.
// The unused encoding 2'd3 behaves as IDLE.
module cpu6_hazard_drain_fsm
  import cpu6_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  output logic o_busy,
  output logic o_done
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  logic [CPU6_HAZ_STATE_SIZE-1:0] r_state;
  logic [CPU6_HAZ_STATE_SIZE-1:0] w_state_next;
  logic [CNT_W-1:0]               r_cnt;
  logic [CNT_W-1:0]               w_cnt_next;

  // NOTE: defaults first so every path assigns every output (no latches).
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      CPU6_HAZ_DRAIN: begin
        if (r_cnt == '0) w_state_next = CPU6_HAZ_RELEASE;
        else             w_cnt_next   = r_cnt - CNT_W'(1);
      end
      CPU6_HAZ_RELEASE: w_state_next = CPU6_HAZ_IDLE;
      default: begin
        if (i_start) begin
          w_state_next = CPU6_HAZ_DRAIN;
          w_cnt_next   = CNT_LOAD;
        end
      end
    endcase
  end

  cpu6_dffr #(.W(CPU6_HAZ_STATE_SIZE), .RST_VAL(CPU6_HAZ_IDLE)) u_state_reg (
    .clk   (clk),
    .reset (reset),
    .i_d   (w_state_next),
    .o_q   (r_state)
  );

  cpu6_dffr #(.W(CNT_W), .RST_VAL('0)) u_cnt_reg (
    .clk   (clk),
    .reset (reset),
    .i_d   (w_cnt_next),
    .o_q   (r_cnt)
  );

  assign o_busy = (r_state == CPU6_HAZ_DRAIN);
  assign o_done = (r_state == CPU6_HAZ_RELEASE);

endmodule

// File: rtl/cpu6_hazard_ctrl.sv
// cpu6 pipeline sequencer: stall/flush controls for IF/ID, ID/EX and the PC,
// covering load-use, E-stage redirects and CSR-driven pipeline drains.
module cpu6_hazard_ctrl
  import cpu6_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 2,
  parameter int PERF_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu6_hazard_ctrl_if.slave    hz
);

  logic              w_start;
  logic              w_busy;
  logic              w_done;
  logic              w_load_use;
  haz_ctrl_t         w_ctrl;
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] w_stall_cnt_next;

  // A redirect squashes the drain requester, so it must not start a drain.
  assign w_start = hz.empty_pipeline_reqE & ~hz.redirectE;

  cpu6_hazard_drain_fsm #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) u_drain_fsm (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .o_busy  (w_busy),
    .o_done  (w_done)
  );

  assign w_load_use = load_use(hz.memtoregE, hz.rdE, hz.rs1D, hz.rs2D,
                               hz.use_rs1D, hz.use_rs2D);

  // While draining, E only holds bubbles, so the hazard inputs are ignored.
  always_comb begin
    w_ctrl = HAZ_NONE;
    if (reset)              w_ctrl = HAZ_NONE;
    else if (w_busy)        w_ctrl = HAZ_STALL;
    else if (hz.redirectE)  w_ctrl = HAZ_REDIRECT;
    else if (w_load_use)    w_ctrl = HAZ_STALL;
  end

  assign w_stall_cnt_next = (w_ctrl.stall_f && (r_stall_cnt != '1))
                          ? r_stall_cnt + PERF_W'(1) : r_stall_cnt;

  cpu6_dffr #(.W(PERF_W), .RST_VAL('0)) u_stall_cnt_reg (
    .clk   (clk),
    .reset (reset),
    .i_d   (w_stall_cnt_next),
    .o_q   (r_stall_cnt)
  );

  assign hz.stallF     = w_ctrl.stall_f;
  assign hz.stallD     = w_ctrl.stall_d;
  assign hz.flashD     = w_ctrl.flash_d;
  assign hz.flashE     = w_ctrl.flash_e;
  assign hz.drain_busy = w_busy & ~reset;
  assign hz.drain_done = w_done & ~reset;
  assign hz.stall_cnt  = r_stall_cnt;

endmodule
